// File: rtl/lz77_pkg.sv
// lz77_pkg: shared types and default sizing for the LZ77 search controller.
//   state_t  - controller FSM states
//   token_t  - emitted token {offset, match_len, char_nxt}
//   *_DEF    - default STR_LEN / SEARCH_SIZE / LA_SIZE
package lz77_pkg;

  localparam int unsigned STR_LEN_DEF     = 2048;
  localparam int unsigned SEARCH_SIZE_DEF = 9;
  localparam int unsigned LA_SIZE_DEF     = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    EMIT,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    logic [3:0] offset;
    logic [2:0] match_len;
    logic [7:0] char_nxt;
  } token_t;

endpackage

// File: rtl/lz77_best_match.sv
// lz77_best_match: best-match tracker for one search sweep.
//   clk, reset  - clock, synchronous active-high reset
//   clear       - zero the tracked best (start of a sweep)
//   update      - evaluate the candidate presented this cycle
//   last_idx    - candidate is the final offset of the sweep
//   ptr         - current string pointer
//   idx         - offset of the candidate
//   cmp_len     - raw comparator match length for idx
//   cmp_nxt     - character following that match
//   best_next   - best token including this cycle's candidate
//   sweep_end   - sweep may stop after this cycle
// Optional: LZ77_EARLY_TERM_EN ends the sweep once the best length equals
// the largest length still encodable at ptr.
module lz77_best_match
  import lz77_pkg::*;
#(
  parameter int unsigned STR_LEN = STR_LEN_DEF,
  parameter int unsigned LA_SIZE = LA_SIZE_DEF,
  parameter int unsigned PW      = $clog2(STR_LEN) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          update,
  input  logic          last_idx,
  input  logic [PW-1:0] ptr,
  input  logic [3:0]    idx,
  input  logic [2:0]    cmp_len,
  input  logic [7:0]    cmp_nxt,
  output token_t        best_next,
  output logic          sweep_end
);

  // Wide enough for both ptr and a 4-bit offset.
  localparam int unsigned CW = (PW > 4) ? PW : 4;

  token_t        best_q;
  logic [CW-1:0] remain;
  logic [2:0]    limit;
  logic [2:0]    eff_len;
  logic          eligible;

  always_comb begin
    // The final string character must remain available as char_nxt.
    remain = CW'(STR_LEN - 1) - CW'(ptr);
    if (remain < CW'(LA_SIZE - 1)) begin
      limit = remain[2:0];
    end else begin
      limit = 3'(LA_SIZE - 1);
    end
    eff_len  = (cmp_len < limit) ? cmp_len : limit;
    eligible = CW'(idx) < CW'(ptr);

    best_next = best_q;
    if (update) begin
      // Offset 0 always supplies the look-ahead head for a literal token.
      if (idx == '0) begin
        best_next.char_nxt = cmp_nxt;
      end
      // Strict compare keeps the smallest offset on ties.
      if (eligible && (eff_len > best_q.match_len)) begin
        best_next.offset    = idx;
        best_next.match_len = eff_len;
        best_next.char_nxt  = cmp_nxt;
      end
    end

`ifdef LZ77_EARLY_TERM_EN
    sweep_end = last_idx || (best_next.match_len == limit);
`else
    sweep_end = last_idx;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      best_q <= '0;
    end else begin
      best_q <= best_next;
    end
  end

endmodule

// File: rtl/lz77_search_ctrl.sv
// lz77_search_ctrl: sequences the LZ77 match datapath. Sweeps search-window
// offsets, tracks the best match, emits one token, then commands the shift.
//   clk, reset   - clock, synchronous active-high reset
//   start        - begin encoding (accepted in IDLE only)
//   cmp_offset   - offset presented to the comparator datapath
//   cmp_len      - comparator match length for cmp_offset (same cycle)
//   cmp_nxt      - character following that match (same cycle)
//   shift_en     - one-cycle datapath advance strobe
//   shift_amt    - match_len+1 of the token just emitted (while shift_en)
//   busy/encode  - high in SEARCH, EMIT, SHIFT
//   valid        - one-cycle token strobe
//   finish       - high in DONE until reset
//   offset, match_len, char_nxt - token, held between valid pulses
// Optional: LZ77_EARLY_TERM_EN cuts the sweep short once the best match
// cannot be improved; token values are unchanged.
module lz77_search_ctrl
  import lz77_pkg::*;
#(
  parameter int unsigned STR_LEN     = STR_LEN_DEF,
  parameter int unsigned SEARCH_SIZE = SEARCH_SIZE_DEF,
  parameter int unsigned LA_SIZE     = LA_SIZE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] cmp_offset,
  input  logic [2:0] cmp_len,
  input  logic [7:0] cmp_nxt,
  output logic       shift_en,
  output logic [3:0] shift_amt,
  output logic       busy,
  output logic       valid,
  output logic       encode,
  output logic       finish,
  output logic [3:0] offset,
  output logic [2:0] match_len,
  output logic [7:0] char_nxt
);

  localparam int unsigned PW = $clog2(STR_LEN) + 1;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    idx;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_adv;
  token_t        tok;
  token_t        best_next;
  logic          clear;
  logic          update;
  logic          load_tok;
  logic          last_idx;
  logic          sweep_end;

  lz77_best_match #(
    .STR_LEN (STR_LEN),
    .LA_SIZE (LA_SIZE),
    .PW      (PW)
  ) u_best (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .update    (update),
    .last_idx  (last_idx),
    .ptr       (ptr),
    .idx       (idx),
    .cmp_len   (cmp_len),
    .cmp_nxt   (cmp_nxt),
    .best_next (best_next),
    .sweep_end (sweep_end)
  );

  // Kept separate from the FSM block so the comparator path into
  // sweep_end does not loop back through the next-state logic.
  always_comb begin
    update   = (state == SEARCH);
    last_idx = (idx == 4'(SEARCH_SIZE - 1));
    ptr_adv  = ptr + PW'(tok.match_len) + PW'(1);
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    load_tok  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SEARCH;
          clear     = 1'b1;
        end
      end
      SEARCH: begin
        // Capture the final best (including this cycle) so EMIT presents it.
        if (sweep_end) begin
          state_nxt = EMIT;
          load_tok  = 1'b1;
        end
      end
      EMIT: state_nxt = SHIFT;
      SHIFT: begin
        if (ptr_adv >= PW'(STR_LEN)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SEARCH;
          clear     = 1'b1;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      ptr   <= '0;
      tok   <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        idx <= '0;
      end else if (state == SEARCH) begin
        idx <= idx + 4'd1;
      end
      if ((state == IDLE) && start) begin
        ptr <= '0;
      end else if (state == SHIFT) begin
        ptr <= ptr_adv;
      end
      if (load_tok) begin
        tok <= best_next;
      end
    end
  end

  always_comb begin
    busy       = (state == SEARCH) || (state == EMIT) || (state == SHIFT);
    encode     = busy;
    valid      = (state == EMIT);
    shift_en   = (state == SHIFT);
    shift_amt  = shift_en ? ({1'b0, tok.match_len} + 4'd1) : '0;
    finish     = (state == DONE);
    cmp_offset = (state == SEARCH) ? idx : '0;
    offset     = tok.offset;
    match_len  = tok.match_len;
    char_nxt   = tok.char_nxt;
  end

endmodule

// File: tb/tb_lz77_search_ctrl.sv
// Testbench for lz77_search_ctrl with STR_LEN=16, SEARCH_SIZE=9, LA_SIZE=8.
// A behavioural comparator datapath answers cmp_offset from a 16-char string
// (offset o compares against position ptr-1-o), with an override table to
// inject specific lengths. Expected tokens are hand-computed and queued;
// a monitor pops and compares on every valid/shift_en/finish event.
module tb_lz77_search_ctrl;

  localparam int STR_LEN = 16;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] cmp_offset;
  logic [2:0] cmp_len;
  logic [7:0] cmp_nxt;
  logic       shift_en;
  logic [3:0] shift_amt;
  logic       busy;
  logic       valid;
  logic       encode;
  logic       finish;
  logic [3:0] offset;
  logic [2:0] match_len;
  logic [7:0] char_nxt;

  lz77_search_ctrl #(
    .STR_LEN     (16),
    .SEARCH_SIZE (9),
    .LA_SIZE     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cmp_offset (cmp_offset),
    .cmp_len    (cmp_len),
    .cmp_nxt    (cmp_nxt),
    .shift_en   (shift_en),
    .shift_amt  (shift_amt),
    .busy       (busy),
    .valid      (valid),
    .encode     (encode),
    .finish     (finish),
    .offset     (offset),
    .match_len  (match_len),
    .char_nxt   (char_nxt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- comparator datapath model ----------------
  logic [7:0] str [16];
  int ov_ptr [4];
  int ov_off [4];
  int ov_len [4];
  int nov = 0;
  int ptr_m;

  always @(posedge clk) begin
    if (reset) ptr_m <= 0;
    else if (shift_en) ptr_m <= ptr_m + int'(shift_amt);
  end

  // Match length is limited to 7 and to the string end; the next-char fetch
  // saturates at the last character. Ineligible offsets present the head.
  function automatic logic [10:0] dp_resp(input int p, input int o);
    int len;
    int hd;
    int ni;
    bit go;
    len = 0;
    go  = 1'b1;
    hd  = (p > 15) ? 15 : p;
    if (o < p) begin
      for (int k = 0; k < 7; k++) begin
        if (go) begin
          if ((p + k <= 15) && (str[p-1-o+k] == str[p+k])) len++;
          else go = 1'b0;
        end
      end
    end
    for (int i = 0; i < 4; i++)
      if ((i < nov) && (ov_ptr[i] == p) && (ov_off[i] == o)) len = ov_len[i];
    if (o >= p) ni = hd;
    else ni = p + ((len < 15 - p) ? len : 15 - p);
    return {len[2:0], str[ni]};
  endfunction

  always_comb {cmp_len, cmp_nxt} = dp_resp(ptr_m, int'(cmp_offset));

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0] off;
    logic [2:0] len;
    logic [7:0] nxt;
    int         gap;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   ref_cyc   = 0;
  int   last_len  = 0;
  int   shift_cnt = 0;
  bit   shift_d   = 1'b0;
  bit   fin_d     = 1'b0;

  task automatic push(input int off, input int len, input int nxt,
                      input int gap, input int gap_et);
    exp_t e;
    e.off = off[3:0];
    e.len = len[2:0];
    e.nxt = nxt[7:0];
`ifdef LZ77_EARLY_TERM_EN
    e.gap = gap_et;
`else
    e.gap = gap;
`endif
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL token_unexpected: got (%0d,%0d,%02h), required none",
                   offset, match_len, char_nxt);
        end else begin
          e_mon = q.pop_front();
          last_len = int'(e_mon.len);
          if ({offset, match_len, char_nxt} !== {e_mon.off, e_mon.len, e_mon.nxt}) begin
            errors++;
            $display("FAIL token: got (%0d,%0d,%02h) required (%0d,%0d,%02h)",
                     offset, match_len, char_nxt, e_mon.off, e_mon.len, e_mon.nxt);
          end
          checks++;
          if (cyc - ref_cyc != e_mon.gap) begin
            errors++;
            $display("FAIL token_gap: got %0d cycles required %0d", cyc - ref_cyc, e_mon.gap);
          end
        end
        ref_cyc = cyc;
        checks++;
        if (!(busy && encode)) begin
          errors++;
          $display("FAIL busy_emit: got busy=%0b encode=%0b required 1,1", busy, encode);
        end
      end
      if (shift_en) begin
        checks++;
        shift_cnt++;
        if (shift_amt !== 4'(last_len + 1)) begin
          errors++;
          $display("FAIL shift_amt: got %0d required %0d", shift_amt, last_len + 1);
        end
      end
      if (finish && !fin_d) begin
        checks++;
        if (!shift_d) begin
          errors++;
          $display("FAIL finish_timing: got previous shift_en=0 required 1");
        end
      end
    end
    shift_d = shift_en;
    fin_d   = finish;
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start;
    @(negedge clk);
    start   = 1'b1;
    ref_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string name);
    logic [29:0] outs;
    outs = {busy, valid, encode, finish, shift_en, shift_amt, cmp_offset,
            offset, match_len, char_nxt};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL %s: got outputs %h required 0", name, outs);
    end
  endtask

  task automatic check_q_empty(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending tokens required 0", name, q.size());
    end
  endtask

  task automatic wait_finish(input string name, input int budget);
    int n;
    n = 0;
    while (!finish && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!finish) begin
      errors++;
      $display("FAIL %s_timeout: got finish=0 after %0d cycles required 1", name, budget);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) str[i] = 8'(65 + i);   // "ABCDEFGHIJKLMNOP"
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;

    // Literal string, aborted by reset in the 4th SEARCH cycle of token 3.
    shift_cnt = 0;
    push(0, 0, 65, 10, 10);
    push(0, 0, 66, 11, 11);
    pulse_start();
    n = 0;
    while (!(shift_cnt >= 2 && busy && cmp_offset == 4'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(busy && cmp_offset == 4'd3)) begin
      errors++;
      $display("FAIL abort_point: got cmp_offset=%0d busy=%0b required 3,1", cmp_offset, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    reset = 1'b0;
    check_q_empty("abort_tokens");

    // Full literal encode: 16 single-char tokens, re-encoded from ptr 0.
    for (int i = 0; i < 16; i++)
      push(0, 0, 65 + i, (i == 0) ? 10 : 11, (i == 0) ? 10 : ((i == 15) ? 3 : 11));
    pulse_start();
    wait_finish("literal", 300);
    check_q_empty("literal_tokens");

    // start is ignored in DONE.
    pulse_start();
    repeat (3) @(negedge clk);
    checks++;
    if (!(finish && !busy && !valid)) begin
      errors++;
      $display("FAIL done_hold: got finish=%0b busy=%0b valid=%0b required 1,0,0",
               finish, busy, valid);
    end

    // Eligibility and tie: ptr3 offset6 (ineligible) len5, offset1 len2;
    // ptr9 offsets 2 and 5 both len3.
    apply_reset();
    ov_ptr[0] = 3; ov_off[0] = 1; ov_len[0] = 2;
    ov_ptr[1] = 3; ov_off[1] = 6; ov_len[1] = 5;
    ov_ptr[2] = 9; ov_off[2] = 2; ov_len[2] = 3;
    ov_ptr[3] = 9; ov_off[3] = 5; ov_len[3] = 3;
    nov = 4;
    push(0, 0, 65, 10, 10);   // ptr 0 'A'
    push(0, 0, 66, 11, 11);   // ptr 1 'B'
    push(0, 0, 67, 11, 11);   // ptr 2 'C'
    push(1, 2, 70, 11, 11);   // ptr 3 -> 'F', shift 3
    push(0, 0, 71, 11, 11);   // ptr 6 'G'
    push(0, 0, 72, 11, 11);   // ptr 7 'H'
    push(0, 0, 73, 11, 11);   // ptr 8 'I'
    push(2, 3, 77, 11, 11);   // ptr 9 tie -> offset 2, 'M', shift 4
    push(0, 0, 78, 11, 11);   // ptr 13 'N'
    push(0, 0, 79, 11, 11);   // ptr 14 'O'
    push(0, 0, 80, 11, 3);    // ptr 15 'P'
    pulse_start();
    wait_finish("tie", 300);
    check_q_empty("tie_tokens");

    // "aaaa...": clamp at LA_SIZE-1, then at STR_LEN-1-ptr.
    apply_reset();
    nov = 0;
    for (int i = 0; i < 16; i++) str[i] = 8'h61;
    push(0, 0, 97, 10, 10);   // ptr 0
    push(0, 7, 97, 11, 3);    // ptr 1, shift 8
    push(0, 6, 97, 11, 3);    // ptr 9, clamped to 6, shift 7
    pulse_start();
    wait_finish("repeat", 200);
    check_q_empty("repeat_tokens");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
